// File: rtl/xc_sha3_pkg.sv
// Shared definitions for the SHA3 lane index datapath and its address sequencer.
package xc_sha3_pkg;

  localparam int unsigned SHA3_GRID = 5;

  localparam logic [2:0] SHA3_F_XY = 3'd0;
  localparam logic [2:0] SHA3_F_X1 = 3'd1;
  localparam logic [2:0] SHA3_F_X2 = 3'd2;
  localparam logic [2:0] SHA3_F_X4 = 3'd3;
  localparam logic [2:0] SHA3_F_YX = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } agu_state_e;

  // Reduce a value in 0..20 modulo the grid size.
  function automatic logic [2:0] sha3_mod5(input logic [4:0] v);
    logic [4:0] r;
    if (v >= 5'd20)      r = v - 5'd20;
    else if (v >= 5'd15) r = v - 5'd15;
    else if (v >= 5'd10) r = v - 5'd10;
    else if (v >= 5'd5)  r = v - 5'd5;
    else                 r = v;
    return r[2:0];
  endfunction

endpackage

// File: rtl/xc_sha3.sv
// Keccak lane index datapath: maps grid coordinate (x,y) to a shifted lane index.
module xc_sha3
  import xc_sha3_pkg::*;
(
  input  logic [2:0]  rs1,
  input  logic [2:0]  rs2,
  input  logic        f_xy,
  input  logic        f_x1,
  input  logic        f_x2,
  input  logic        f_x4,
  input  logic        f_yx,
  input  logic [1:0]  shamt,
  output logic [31:0] result
);

  logic [2:0] col;
  logic [2:0] row;
  logic [4:0] idx;
  logic [7:0] shifted;

  always_comb begin
    col = 3'd0;
    row = 3'd0;
    if (f_xy) begin
      col = rs1;
      row = rs2;
    end
    if (f_x1) begin
      col = sha3_mod5({2'b00, rs1} + 5'd1);
      row = rs2;
    end
    if (f_x2) begin
      col = sha3_mod5({2'b00, rs1} + 5'd2);
      row = rs2;
    end
    if (f_x4) begin
      col = sha3_mod5({2'b00, rs1} + 5'd4);
      row = rs2;
    end
    if (f_yx) begin
      // YX transposes: y selects the column, (2x+3y)%5 selects the row.
      col = rs2;
      row = sha3_mod5({1'b0, rs1, 1'b0} + {2'b00, rs2} + {1'b0, rs2, 1'b0});
    end
  end

  assign idx     = {2'b00, col} + {row, 2'b00} + {2'b00, row};
  assign shifted = {3'b000, idx} << shamt;
  assign result  = {24'd0, shifted};

endmodule

// File: rtl/xc_sha3_agu.sv
// Lane-sweep address generator: walks the 5x5 (or 5x1) grid, one registered beat per step.
module xc_sha3_agu
  import xc_sha3_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_func,
  input  logic        cmd_rows,
  input  logic [1:0]  cmd_shamt,
  input  logic [31:0] cmd_base,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [2:0]  out_x,
  output logic [2:0]  out_y,
  output logic        out_last,
  output logic        busy,
  output logic        err
);

  // Streams: a beat transfers on out_valid & out_ready and is held unchanged otherwise;
  // a command transfers on cmd_valid & cmd_ready.
  agu_state_e  state_q, state_d;
  logic [2:0]  func_q, func_d;
  logic        rows_q, rows_d;
  logic [1:0]  shamt_q, shamt_d;
  logic [31:0] base_q, base_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        err_q, err_d;
  logic [2:0]  out_x_q, out_x_d;
  logic [2:0]  out_y_q, out_y_d;
  logic [31:0] out_addr_q, out_addr_d;

  logic        idle;
  logic        accept;
  logic [2:0]  step_x, step_y;
  logic [2:0]  sel_x, sel_y, sel_func;
  logic [1:0]  sel_shamt;
  logic [31:0] sel_base;
  logic [31:0] idx_res;
  logic [31:0] sweep_addr;

  assign idle      = (state_q == ST_IDLE);
  assign cmd_ready = idle & ~abort;
  assign accept    = cmd_valid & cmd_ready;

  assign step_x = (out_x_q == 3'd4) ? 3'd0 : out_x_q + 3'd1;
  assign step_y = (out_x_q == 3'd4) ? out_y_q + 3'd1 : out_y_q;

  // While idle the first beat is formed straight from the command so it lands in cycle 1.
  assign sel_x     = idle ? 3'd0 : step_x;
  assign sel_y     = idle ? 3'd0 : step_y;
  assign sel_func  = idle ? cmd_func : func_q;
  assign sel_shamt = idle ? cmd_shamt : shamt_q;
  assign sel_base  = idle ? cmd_base : base_q;

  xc_sha3 u_index (
    .rs1    (sel_x),
    .rs2    (sel_y),
    .f_xy   (sel_func == SHA3_F_XY),
    .f_x1   (sel_func == SHA3_F_X1),
    .f_x2   (sel_func == SHA3_F_X2),
    .f_x4   (sel_func == SHA3_F_X4),
    .f_yx   (sel_func == SHA3_F_YX),
    .shamt  (sel_shamt),
    .result (idx_res)
  );

  assign sweep_addr = sel_base + idx_res;

  always_comb begin
    state_d     = state_q;
    func_d      = func_q;
    rows_d      = rows_q;
    shamt_d     = shamt_q;
    base_d      = base_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_addr_d  = out_addr_q;
    err_d       = 1'b0;
    if (abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            func_d  = cmd_func;
            rows_d  = cmd_rows;
            shamt_d = cmd_shamt;
            base_d  = cmd_base;
            out_x_d = 3'd0;
            out_y_d = 3'd0;
            if (cmd_func <= SHA3_F_YX) begin
              state_d     = ST_RUN;
              out_valid_d = 1'b1;
              out_addr_d  = sweep_addr;
              out_last_d  = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (out_valid_q & out_ready) begin
            if (out_last_q) begin
              state_d     = ST_IDLE;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
            end else begin
              out_x_d    = step_x;
              out_y_d    = step_y;
              out_addr_d = sweep_addr;
              out_last_d = (step_x == 3'd4) && (step_y == (rows_q ? 3'd4 : 3'd0));
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= ST_IDLE;
      func_q      <= 3'd0;
      rows_q      <= 1'b0;
      shamt_q     <= 2'd0;
      base_q      <= 32'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      out_x_q     <= 3'd0;
      out_y_q     <= 3'd0;
      out_addr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      func_q      <= func_d;
      rows_q      <= rows_d;
      shamt_q     <= shamt_d;
      base_q      <= base_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_addr_q  <= out_addr_d;
    end
  end

  // busy mirrors the FSM state and doubles as its observation point.
  assign busy      = (state_q == ST_RUN);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;

endmodule
